// File: rtl/distribution_tree.sv
// distribution_tree: 1-to-FAN_OUT flit distributor, root FIFO feeding L1_N branch FIFOs; define DIST_TREE_DROP_CNT_EN to add the drop_cnt port
module distribution_tree #(
    parameter int FLIT_SIZE = 32,
    parameter int FAN_OUT   = 36,
    parameter int L1_N      = 6,
    parameter int DST_LSB   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_SIZE-1:0]         in,
    input  logic                         in_valid,
    input  logic [FAN_OUT-1:0]           out_avail,
    output logic                         in_avail,
    output logic [FLIT_SIZE*FAN_OUT-1:0] out,
    output logic [FAN_OUT-1:0]           out_valid
`ifdef DIST_TREE_DROP_CNT_EN
    ,
    output logic [15:0]                  drop_cnt
`endif
);
    localparam int L1_W  = FAN_OUT / L1_N;
    localparam int DST_W = $clog2(FAN_OUT);

    logic [FLIT_SIZE-1:0] root_mem [2];
    logic                 root_wp;
    logic                 root_rp;
    logic [1:0]           root_cnt;
    logic                 root_push;
    logic                 root_pop;
    logic                 root_drop;
    int                   root_d;
    int                   root_b;
    logic [L1_N-1:0]      br_push;
    logic [L1_N-1:0]      br_full;

    assign in_avail  = !rst && root_cnt != 2'd2;
    assign root_push = in_valid && in_avail;

    // root head decode: discard out-of-range destinations, otherwise forward when the target branch has room
    always_comb begin
        root_d    = int'(root_mem[root_rp][DST_LSB +: DST_W]);
        root_b    = root_d / L1_W;
        root_drop = root_cnt != 2'd0 && root_d >= FAN_OUT;
        br_push   = '0;
        for (int i = 0; i < L1_N; i++)
            br_push[i] = root_cnt != 2'd0 && !root_drop && root_b == i && !br_full[i];
        root_pop  = root_drop || |br_push;
    end

    // root FIFO storage and occupancy; a full FIFO refuses pushes even when popping
    always_ff @(posedge clk) begin
        if (rst) begin
            root_wp  <= 1'b0;
            root_rp  <= 1'b0;
            root_cnt <= 2'd0;
        end else begin
            if (root_push) begin
                root_mem[root_wp] <= in;
                root_wp           <= !root_wp;
            end
            if (root_pop)
                root_rp <= !root_rp;
            root_cnt <= root_cnt + 2'(root_push) - 2'(root_pop);
        end
    end

    for (genvar g = 0; g < L1_N; g++) begin : g_br
        logic [FLIT_SIZE-1:0] mem [2];
        logic                 wp;
        logic                 rp;
        logic [1:0]           cnt;
        logic [FLIT_SIZE-1:0] head;
        int                   leaf;
        logic                 pop;

        assign head       = mem[rp];
        assign br_full[g] = cnt == 2'd2;

        // head leaf select and handshake with the single addressed output
        always_comb begin
            leaf = int'(head[DST_LSB +: DST_W]) % L1_W;
            pop  = 1'b0;
            for (int j = 0; j < L1_W; j++)
                if (leaf == j)
                    pop = cnt != 2'd0 && out_avail[g*L1_W + j];
        end

        // branch FIFO storage and occupancy, fed from the root head
        always_ff @(posedge clk) begin
            if (rst) begin
                wp  <= 1'b0;
                rp  <= 1'b0;
                cnt <= 2'd0;
            end else begin
                if (br_push[g]) begin
                    mem[wp] <= root_mem[root_rp];
                    wp      <= !wp;
                end
                if (pop)
                    rp <= !rp;
                cnt <= cnt + 2'(br_push[g]) - 2'(pop);
            end
        end

        for (genvar j = 0; j < L1_W; j++) begin : g_leaf
            assign out[(g*L1_W + j)*FLIT_SIZE +: FLIT_SIZE] = head;
            assign out_valid[g*L1_W + j] = !rst && cnt != 2'd0 && leaf == j;
        end
    end

`ifdef DIST_TREE_DROP_CNT_EN
    // saturating count of out-of-range flits discarded at the root
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (root_drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_distribution_tree.sv
// tb_distribution_tree: directed table, corner sequences and random traffic against a per-output queue model
module tb_distribution_tree;
    localparam int FS = 32;
    localparam int N  = 36;

    typedef struct {
        int           d;
        logic [N-1:0] exp_valid;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [FS-1:0]   flit = '0;
    logic            in_valid = 1'b0;
    logic [N-1:0]    oav = '0;
    logic            in_avail;
    logic [FS*N-1:0] out;
    logic [N-1:0]    out_valid;
`ifdef DIST_TREE_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    int            checks = 0;
    int            failures = 0;
    int            drops = 0;
    int            dlv [N];
    logic [FS-1:0] q [N][$];
    vec_t          vecs [8];

    always #5 clk = ~clk;

    distribution_tree dut (
        .clk(clk),
        .rst(rst),
        .in(flit),
        .in_valid(in_valid),
        .out_avail(oav),
        .in_avail(in_avail),
        .out(out),
        .out_valid(out_valid)
`ifdef DIST_TREE_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++)
            s += q[k].size();
        return s;
    endfunction

    function automatic logic [FS-1:0] mk(input int d);
        logic [FS-1:0] r = $urandom();
        r[5:0] = 6'(d);
        return r;
    endfunction

    function automatic int total_dlv();
        int s = 0;
        for (int k = 0; k < N; k++)
            s += dlv[k];
        return s;
    endfunction

    // one clock: record accepted flits in the model, check every delivery against it
    task automatic tick();
        int            d;
        logic [FS-1:0] got;
        logic [FS-1:0] exp;
        #1;
        if (in_valid && in_avail) begin
            d = int'(flit[5:0]);
            if (d < N)
                q[d].push_back(flit);
            else
                drops++;
        end
        for (int k = 0; k < N; k++) begin
            if (out_valid[k] && oav[k]) begin
                got = out[k*FS +: FS];
                dlv[k]++;
                checks++;
                if (q[k].size() == 0) begin
                    failures++;
                    $display("FAIL deliver_unexpected out=%0d actual=%h required=none", k, got);
                end else begin
                    exp = q[k].pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL deliver_data out=%0d actual=%h required=%h", k, got, exp);
                    end
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++)
                q[k].delete();
            drops = 0;
        end
        @(negedge clk);
    endtask

    task automatic send(input int d, input string name);
        logic ok = 1'b0;
        flit     = mk(d);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_avail;
            tick();
        end
        in_valid = 1'b0;
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic drain(input string name);
        oav      = '1;
        in_valid = 1'b0;
        for (int i = 0; i < 300 && pending() != 0; i++)
            tick();
        repeat (4) tick();
        chk(name, 64'(pending()), 64'd0);
    endtask

    initial begin
        int            idx;
        int            base;
        int            b20;
        int            b1;
        logic          a;
        logic [N-1:0]  e;
        logic [N-1:0]  one;
        logic [FS-1:0] f;
        logic [FS-1:0] f3 [5];

        for (int k = 0; k < N; k++)
            dlv[k] = 0;
        vecs[0] = '{0,  36'h000000001};
        vecs[1] = '{35, 36'h800000000};
        vecs[2] = '{7,  36'h000000080};
        vecs[3] = '{20, 36'h000100000};
        vecs[4] = '{6,  36'h000000040};
        vecs[5] = '{40, 36'h000000000};
        vecs[6] = '{63, 36'h000000000};
        vecs[7] = '{17, 36'h000020000};

        @(negedge clk);
        tick();
        tick();
        chk("reset_in_avail", 64'(in_avail), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_release_in_avail", 64'(in_avail), 64'd1);
`ifdef DIST_TREE_DROP_CNT_EN
        chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

        // single flits: exact two-cycle latency, one-hot valid, data on the addressed slice
        oav = '1;
        for (int v = 0; v < 8; v++) begin
            f        = mk(vecs[v].d);
            flit     = f;
            in_valid = 1'b1;
            chk("t1_in_avail", 64'(in_avail), 64'd1);
            tick();
            in_valid = 1'b0;
            chk("t1_early", 64'(out_valid), 64'd0);
            tick();
            chk("t1_valid", 64'(out_valid), 64'(vecs[v].exp_valid));
            if (vecs[v].exp_valid != '0)
                chk("t1_data", 64'(out[vecs[v].d*FS +: FS]), 64'(f));
            tick();
            chk("t1_after", 64'(out_valid), 64'd0);
        end

        // back-to-back d=0..35 at full rate
        one = 1;
        for (int c = 0; c < 39; c++) begin
            e = (c >= 2 && c < 38) ? one << (c - 2) : '0;
            chk("t2_valid", 64'(out_valid), 64'(e));
            if (c < 36) begin
                chk("t2_in_avail", 64'(in_avail), 64'd1);
                flit     = mk(c);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        drain("t2_drain");

        // five flits to a stalled output: root and branch fill after four
        oav  = '0;
        idx  = 0;
        base = dlv[7];
        for (int i = 0; i < 5; i++)
            f3[i] = mk(7);
        for (int i = 0; i < 10; i++) begin
            in_valid = idx < 5;
            flit     = f3[idx < 5 ? idx : 4];
            a        = in_valid && in_avail;
            tick();
            if (a)
                idx++;
        end
        chk("t3_accepted", 64'(idx), 64'd4);
        chk("t3_in_avail", 64'(in_avail), 64'd0);
        chk("t3_held", 64'(dlv[7] - base), 64'd0);
        chk("t3_valid_held", 64'(out_valid), 64'h80);
        oav[7] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = idx < 5;
            flit     = f3[idx < 5 ? idx : 4];
            a        = in_valid && in_avail;
            tick();
            if (a)
                idx++;
        end
        chk("t3_fifth", 64'(idx), 64'd5);
        drain("t3_drain");
        chk("t3_count", 64'(dlv[7] - base), 64'd5);

        // branch 0 stalled: other branches pass until branch 0 fills and blocks the root
        oav = ~36'h3F;
        b20 = dlv[20];
        send(3, "t4_send3");
        send(20, "t4_send20");
        repeat (4) tick();
        chk("t4_d20_passes", 64'(dlv[20] - b20), 64'd1);
        chk("t4_d3_held", 64'(q[3].size()), 64'd1);
        send(3, "t4_send3b");
        send(3, "t4_send3c");
        send(20, "t4_send20b");
        repeat (6) tick();
        chk("t4_hol", 64'(dlv[20] - b20), 64'd1);
        chk("t4_hol_in_avail", 64'(in_avail), 64'd0);
        oav[3] = 1'b1;
        drain("t4_drain");
        chk("t4_d20_late", 64'(dlv[20] - b20), 64'd2);

        // out-of-range destinations vanish, in-range ones still arrive
        oav = '1;
        b1  = dlv[1];
        send(40, "t5_send40");
        send(1, "t5_send1");
        send(63, "t5_send63");
        send(1, "t5_send1b");
        drain("t5_drain");
        chk("t5_d1", 64'(dlv[1] - b1), 64'd2);
`ifdef DIST_TREE_DROP_CNT_EN
        chk("t5_drop_cnt", 64'(drop_cnt), 64'(drops));
        flit     = mk(63);
        in_valid = 1'b1;
        repeat (65537) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t5_drop_sat", 64'(drop_cnt), 64'(drops > 65535 ? 65535 : drops));
`endif

        // reset while every FIFO is full: nothing stale survives
        oav = '0;
        for (int i = 0; i < 16; i++) begin
            flit     = mk((i * 3) % 36);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t6_full", 64'(in_avail), 64'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_avail", 64'(in_avail), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_in_avail_after", 64'(in_avail), 64'd1);
`ifdef DIST_TREE_DROP_CNT_EN
        chk("t6_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        base = total_dlv();
        oav  = '1;
        repeat (10) tick();
        chk("t6_no_stale", 64'(total_dlv() - base), 64'd0);
        chk("t6_quiet", 64'(out_valid), 64'd0);

        // random traffic with random backpressure; upstream holds a refused flit
        a = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            oav = N'({$urandom(), $urandom()}) | N'({$urandom(), $urandom()});
            if (a || !in_valid) begin
                in_valid = $urandom_range(0, 9) < 7;
                flit     = mk($urandom_range(0, 7) == 0 ? $urandom_range(36, 63) : $urandom_range(0, 35));
            end
            a = in_valid && in_avail;
            tick();
        end
        drain("rand_drain");
`ifdef DIST_TREE_DROP_CNT_EN
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(drops > 65535 ? 65535 : drops));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
